// File: rtl/xilinx_clock_pkg.sv
// Shared types and sizing helpers for the MMCM sequencing controller.
package xilinx_clock_pkg;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        SETTLE,
        RUN,
        PWRDN,
        FAULT
    } clkctrl_state_e;

    localparam int RELOCK_CNT_W = 8;

    // One shared counter serves every timed state, so it is sized for the longest interval.
    function automatic int clkctrl_cnt_w(input int rst_cycles, input int lock_timeout,
                                         input int settle_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (settle_cycles > m) m = settle_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clkctrl_sync.sv
// Parameterised-width two-flop synchronizer with synchronous active-low clear.
module clkctrl_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (!resn) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/xilinx_clock_ctrl.sv
// MMCM reset/power-down sequencer running on the free-running board clock.
// Optional relock statistics counter enabled by XILINX_CLOCK_CTRL_STATS_EN.
module xilinx_clock_ctrl
    import xilinx_clock_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic clk_in,
    input  logic resn,
    input  logic mmcm_locked,
    input  logic pwrdwn_req,
    output logic mmcm_rst,
    output logic mmcm_pwrdwn,
    output logic core_resn,
    output logic locked,
    output logic fault
`ifdef XILINX_CLOCK_CTRL_STATS_EN
    ,
    output logic [RELOCK_CNT_W-1:0] relock_count
`endif
);

    localparam int CNT_W   = clkctrl_cnt_w(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    // The WAIT_LOCK cycle that first sees lock_s counts towards the settle run,
    // so SETTLE itself only needs SETTLE_CYCLES-1 more clean samples.
    localparam int SETTLE_LAST_I = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_LAST_I);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    clkctrl_state_e     state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic               lock_s;

    logic mmcm_rst_reg;
    logic mmcm_pwrdwn_reg;
    logic core_resn_reg;
    logic locked_reg;
    logic fault_reg;

`ifdef XILINX_CLOCK_CTRL_STATS_EN
    logic                    relock_evt;
    logic [RELOCK_CNT_W-1:0] relock_count_reg;
`endif

    clkctrl_sync #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk (clk_in),
        .resn(resn),
        .d   (mmcm_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
`ifdef XILINX_CLOCK_CTRL_STATS_EN
        relock_evt = 1'b0;
`endif
        // Power-down overrides every lock/timeout event; only a fault is sticky against it.
        if (pwrdwn_req && state_reg != FAULT) begin
            state_next = PWRDN;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                RESET: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = SETTLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == RETRY_MAX) begin
                            state_next = FAULT;
                        end else begin
                            state_next = RESET;
                            retry_next = retry_reg + RETRY_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == SETTLE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_next = RESET;
                        cnt_next   = '0;
`ifdef XILINX_CLOCK_CTRL_STATS_EN
                        relock_evt = 1'b1;
`endif
                    end
                end
                PWRDN: begin
                    state_next = RESET;
                    cnt_next   = '0;
                    retry_next = '0;
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = RESET;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_in) begin
        if (!resn) begin
            state_reg       <= RESET;
            cnt_reg         <= '0;
            retry_reg       <= '0;
            mmcm_rst_reg    <= 1'b1;
            mmcm_pwrdwn_reg <= 1'b0;
            core_resn_reg   <= 1'b0;
            locked_reg      <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            retry_reg       <= retry_next;
            mmcm_rst_reg    <= (state_next == RESET) || (state_next == PWRDN) ||
                               (state_next == FAULT);
            mmcm_pwrdwn_reg <= (state_next == PWRDN);
            core_resn_reg   <= (state_next == RUN);
            locked_reg      <= (state_next == RUN);
            fault_reg       <= (state_next == FAULT);
        end
    end

`ifdef XILINX_CLOCK_CTRL_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!resn) begin
            relock_count_reg <= '0;
        end else if (relock_evt && relock_count_reg != {RELOCK_CNT_W{1'b1}}) begin
            relock_count_reg <= relock_count_reg + RELOCK_CNT_W'(1);
        end
    end

    assign relock_count = relock_count_reg;
`endif

    assign mmcm_rst    = mmcm_rst_reg;
    assign mmcm_pwrdwn = mmcm_pwrdwn_reg;
    assign core_resn   = core_resn_reg;
    assign locked      = locked_reg;
    assign fault       = fault_reg;

endmodule
